// File: rtl/freq_pulse_decoder.sv
// freq_pulse_decoder: recovers bytes from a frequency-keyed pulse train by counting edges per gate window.
// Define FREQ_DEC_PARITY_EN to add a 9th even-parity window per frame.
module freq_pulse_decoder #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 8,
    parameter int ZERO_MIN    = 2,
    parameter int ZERO_MAX    = 5,
    parameter int ONE_MIN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pulse_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       bit_err,
    output logic       busy,
    output logic       parity_err
);
    localparam int WW = $clog2(GATE_CYCLES);
    localparam logic [WW-1:0]    WIN_LAST = WW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ZMIN     = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] ZMAX     = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] OMIN     = CNT_W'(ONE_MIN);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3, rise;
    logic [WW-1:0]    win_cnt;
    logic [CNT_W-1:0] edge_cnt, total;
    logic [7:0]       shreg, sh_nxt;
    logic [3:0]       bit_cnt;
    logic             last, silent, one, err;

    assign rise = s2 & ~s3;
    assign busy = state == RECEIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, s3} <= '0;
            state        <= IDLE;
        end else begin
            {s1, s2, s3} <= {pulse_in, s1, s2};
            state        <= state_nxt;
        end
    end

    // total includes an edge arriving in the current cycle, so the last window cycle is classified in full
    always_comb begin
        total     = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + CNT_W'(rise);
        last      = win_cnt == WIN_LAST;
        silent    = total < ZMIN;
        one       = total >= OMIN;
        err       = !silent && !one && total > ZMAX;
        sh_nxt    = {one, shreg[7:1]};
        state_nxt = state;
        if (!ena)
            state_nxt = IDLE;
        else if (state == IDLE)
            state_nxt = rise ? RECEIVE : IDLE;
        else if (last && (silent || err))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            bit_err    <= 1'b0;
`ifdef FREQ_DEC_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            bit_err    <= 1'b0;
`ifdef FREQ_DEC_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!ena || state == IDLE) begin
                win_cnt  <= (ena && rise) ? WW'(1) : '0;
                edge_cnt <= (ena && rise) ? CNT_W'(1) : '0;
                shreg    <= '0;
                bit_cnt  <= '0;
            end else if (!last) begin
                win_cnt  <= win_cnt + WW'(1);
                edge_cnt <= total;
            end else begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                if (silent || err) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    bit_err <= err;
                end
`ifdef FREQ_DEC_PARITY_EN
                else if (bit_cnt == 4'd8) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (one == ^shreg) begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                    end else begin
                        parity_err <= 1'b1;
                    end
                end
`endif
                else begin
                    shreg   <= sh_nxt;
                    bit_cnt <= bit_cnt + 4'd1;
`ifndef FREQ_DEC_PARITY_EN
                    if (bit_cnt == 4'd7) begin
                        bit_cnt    <= '0;
                        data_out   <= sh_nxt;
                        data_valid <= 1'b1;
                    end
`endif
                end
            end
        end
    end

`ifndef FREQ_DEC_PARITY_EN
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_freq_pulse_decoder.sv
// tb_freq_pulse_decoder: random and directed pulse trains, symbol-level reference model and strobe scoreboard.
module tb_freq_pulse_decoder;
    localparam int GATE = 64;
`ifdef FREQ_DEC_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 0, rst_n = 0, ena = 0, pulse_in = 0;
    logic [7:0] data_out;
    logic       data_valid, bit_err, busy, parity_err;

    freq_pulse_decoder #(.GATE_CYCLES(GATE)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pulse_in(pulse_in),
        .data_out(data_out), .data_valid(data_valid), .bit_err(bit_err),
        .busy(busy), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = data_valid, 1 = bit_err, 2 = parity_err
    typedef struct {int kind; int data; int t;} ev_t;
    ev_t exp_q[$];
    int  compared = 0, mismatched = 0;
    int  bits[$];
    int  last_data = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // symbols: 0 = bit 0, 1 = bit 1, 2 = error band, 3 = silence
    function automatic int period_of(input int sym);
        if (sym == 0) return $urandom_range(0, 1) ? 16 : 14;
        if (sym == 1) return 6;
        if (sym == 2) return $urandom_range(0, 1) ? 10 : 12;
        return 0;
    endfunction

    // 3-cycle high pulses every p cycles; the window's last cycle is always low
    task automatic drive(input int p, input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            pulse_in = (p != 0) && (c % p < 3) && (c - c % p + 3 <= GATE - 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic model(input int sym, input int start);
        int b;
        ev_t e;
        e.t = start + 66;
        if (sym == 3) begin
            bits.delete();
        end else if (sym == 2) begin
            e.kind = 1; e.data = last_data; exp_q.push_back(e);
            bits.delete();
        end else begin
            bits.push_back(sym);
            if (bits.size() == FRAME) begin
                b = 0;
                for (int i = 0; i < 8; i++) b |= bits[i] << i;
                if (FRAME == 8 || bits[FRAME-1] == ($countones(b) & 1)) begin
                    last_data = b; e.kind = 0;
                end else begin
                    e.kind = 2;
                end
                e.data = last_data;
                exp_q.push_back(e);
                bits.delete();
            end
        end
    endtask

    task automatic window(input int sym);
        int p, start;
        p = period_of(sym);
        start = cyc;
        drive(p, 0, 32);
        if (sym != 3) check("busy_in_window", busy, 1);
        drive(p, 32, GATE);
        model(sym, start);
    endtask

    task automatic burst(input int q[$]);
        foreach (q[i]) window(q[i]);
        window(3);
        window(3);
        check("busy_after_silence", busy, 0);
    endtask

    task automatic send_byte(input int b, input int flip);
        int q[$];
        for (int i = 0; i < 8; i++) q.push_back((b >> i) & 1);
        if (FRAME == 9) q.push_back(($countones(b) & 1) ^ flip);
        burst(q);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (data_valid || bit_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'b0, parity_err, bit_err, data_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {29'b0, parity_err, bit_err, data_valid}, 1 << e.kind);
                check("strobe_data_out", data_out, e.data);
                check("strobe_cycle", cyc, e.t);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d strobes outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 0);
        check("reset_flags", {data_valid, bit_err, parity_err, busy}, 0);
        rst_n = 1; ena = 1;
        repeat (2) @(posedge clk);
        #1;

        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);

        q = {0, 0, 0, 2};
        for (int i = 0; i < 8; i++) q.push_back(1);
        if (FRAME == 9) q.push_back(0);
        burst(q);

        q = {0, 1, 1};
        burst(q);
        check("held_after_silence", data_out, last_data);

        // asynchronous reset in the middle of window 5
        for (int i = 0; i < 5; i++) drive(6, 0, GATE);
        drive(6, 0, 20);
        #2 rst_n = 0;
        #1;
        check("async_reset_data_out", data_out, 0);
        check("async_reset_flags", {data_valid, bit_err, parity_err, busy}, 0);
        pulse_in = 0; last_data = 0; bits.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        drive(0, 0, GATE);
        check("after_reset_data_out", data_out, 0);

        // enable dropped mid-byte
        send_byte(8'h3C, 0);
        for (int i = 0; i < 3; i++) drive(6, 0, GATE);
        drive(6, 0, 10);
        ena = 0;
        @(posedge clk); #1;
        check("busy_after_ena_drop", busy, 0);
        drive(6, 11, GATE);
        drive(0, 0, GATE);
        ena = 1;
        drive(0, 0, GATE);
        check("held_after_ena_drop", data_out, last_data);

        send_byte(8'h01, 1);

        repeat (10) begin
            q.delete();
            repeat ($urandom_range(1, 24)) begin
                r = $urandom_range(0, 99);
                q.push_back(r < 45 ? 0 : r < 90 ? 1 : r < 95 ? 2 : 3);
            end
            burst(q);
        end
        repeat (8) send_byte($urandom_range(0, 255), $urandom_range(0, 3) == 0);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/freq_pulse_decoder.md
Name: freq_pulse_decoder

Overview:
Receive-side counterpart of the frequency encoder. Recovers bytes from a frequency-keyed pulse train on a pad input by counting rising edges in fixed gate windows. Each window's count is classified as bit 0 (low frequency), bit 1 (high frequency), silence or error. Sits between uio_in[0] and the uio_out data byte in the top level.

Parameters:
GATE_CYCLES, 1000, clk cycles per bit window (>= 4)
CNT_W, 8, edge-counter width; counter saturates at 2^CNT_W-1
ZERO_MIN, 2, minimum edge count that is not silence
ZERO_MAX, 5, maximum edge count decoded as bit 0
ONE_MIN, 8, minimum edge count decoded as bit 1 (ONE_MIN > ZERO_MAX+1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low forces IDLE and discards any partial byte
pulse_in  input  1  asynchronous pulse train from the pad
data_out  output  8  last complete byte; held until the next byte completes
data_valid  output  1  one-cycle strobe when data_out updates
bit_err  output  1  one-cycle strobe on an out-of-band window count
busy  output  1  high while in RECEIVE
parity_err  output  1  one-cycle strobe on parity mismatch (tied 0 without the macro)

Behaviour:
- Reset is asynchronous and active-low on rst_n; the design has one clock, clk. Under reset, state = IDLE and all counters, the shift register, data_out, data_valid, bit_err, busy and parity_err are 0.
- Input path: 2-FF synchronizer on pulse_in, then a rising-edge detector (1 cycle wide). pulse_in is never used unsynchronized.
- State IDLE: busy=0. On the first detected edge with ena=1, go to RECEIVE. That cycle is window cycle 0, edge_cnt=1, bit_cnt=0.
- State RECEIVE: win_cnt increments every cycle. edge_cnt adds 1 per detected edge and saturates at 2^CNT_W-1.
- On the cycle where win_cnt==GATE_CYCLES-1, classify the final count, including any edge in that cycle:
  - count < ZERO_MIN: silence. Discard the partial byte and go to IDLE. No strobe.
  - ZERO_MIN..ZERO_MAX: bit 0.
  - ONE_MIN..max: bit 1.
  - ZERO_MAX+1..ONE_MIN-1: pulse bit_err for 1 cycle, discard the partial byte, go to IDLE.
- Valid bits are shifted LSB-first: the shift register moves right and the new bit enters bit 7. bit_cnt increments.
- The next window starts on the following cycle with win_cnt=0 and edge_cnt=0. Windows run back to back with no gap.
- On the 8th valid bit: data_out loads the full shift register, data_valid=1 for exactly 1 cycle, bit_cnt=0, and the block stays in RECEIVE for the next byte.
- Latency: data_valid and bit_err are registered and assert on the cycle after the last cycle of the deciding window.
- data_valid and bit_err never assert in the same cycle.
- ena low in any state: next cycle state=IDLE and partial byte is cleared. data_out is held and no strobe is issued.
- rst_n asserted mid-frame: immediate clear to reset values.

Optional Feature:
FREQ_DEC_PARITY_EN
- Defined: a 9th window carries an even-parity bit over the 8 data bits.
  - Parity matches: data_out loads and data_valid pulses on the cycle after the 9th window.
  - Parity mismatches: parity_err pulses for 1 cycle, data_out is unchanged, no data_valid.
  - The 9th window is classified like a data window: silence or bit_err still abort.
- Undefined: frames are 8 windows and parity_err is constant 0.

Test Plan:
Settings for all scenarios: GATE_CYCLES=64, default thresholds, ena=1. Period 16 clk gives 4 edges per window (bit 0); period 6 gives 10-11 edges (bit 1); period 10 gives 6-7 edges (error band).
- Train period 16 for 8 windows -> data_out=0x00, data_valid high for exactly 1 cycle; busy stays 1 until pulse_in stops, then falls after one silent window.
- Byte 0xA5 sent LSB-first (1,0,1,0,0,1,0,1 as periods 6/16) -> data_out=0xA5, single data_valid; with FREQ_DEC_PARITY_EN, a 9th window of period 16 (parity 0) is required.
- Three bit-0 windows, then period 10 -> bit_err one cycle after the 4th window, data_valid never asserts; next byte 0xFF decodes correctly.
- Three bits, then pulse_in held low for 64 cycles -> IDLE, no strobe, data_out keeps its previous value.
- rst_n pulsed low mid-window 5 -> all outputs 0 at once (asynchronously); ena dropped mid-byte -> busy=0 next cycle, no data_valid.
- FREQ_DEC_PARITY_EN with 0x01 and parity bit 0 -> parity_err one cycle, data_out unchanged.
